// File: rtl/sn_pkg.sv
// sn_pkg: shared helpers and state type for the snooper width adapter
package sn_pkg;
    typedef enum logic {EMPTY, PARTIAL} sn_state_t;
    function automatic int sn_clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int sn_lane_w(input int ratio);
        return ratio > 1 ? sn_clog2(ratio) : 1;
    endfunction
endpackage

// File: rtl/sn_lane_merge.sv
// sn_lane_merge: drops one beat into its big-endian lane of the output word
module sn_lane_merge
    import sn_pkg::*;
#(
    parameter int IN_WIDTH      = 32,
    parameter int OUT_WIDTH     = 128,
    parameter int LANE_W        = sn_lane_w(OUT_WIDTH / IN_WIDTH),
    parameter int IN_INC_WIDTH  = sn_clog2(IN_WIDTH / 8) + 1,
    parameter int OUT_INC_WIDTH = sn_clog2(OUT_WIDTH / 8) + 1
) (
    input  logic [OUT_WIDTH-1:0]     acc_data,
    input  logic [IN_WIDTH-1:0]      beat,
    input  logic [LANE_W-1:0]        lane,
    input  logic [IN_INC_WIDTH-1:0]  byte_inc,
    input  logic                     clear,
    output logic [OUT_WIDTH-1:0]     merged,
    output logic [OUT_INC_WIDTH-1:0] bytes
);
    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    always_comb begin
        merged = clear ? '0 : acc_data;
        for (int i = 0; i < RATIO; i++)
            if (lane == LANE_W'(i)) merged[OUT_WIDTH-1-i*IN_WIDTH -: IN_WIDTH] = beat;
        bytes = OUT_INC_WIDTH'(lane) * OUT_INC_WIDTH'(IN_WIDTH / 8) + OUT_INC_WIDTH'(byte_inc);
    end
endmodule

// File: rtl/sn_width_adapter_n.sv
// sn_width_adapter_n: gathers narrow snooper beats into wide packet-memory words
module sn_width_adapter_n
    import sn_pkg::*;
#(
    parameter int IN_WIDTH       = 32,
    parameter int OUT_WIDTH      = 128,
    parameter int IN_ADDR_WIDTH  = 10,
    parameter int RATIO          = OUT_WIDTH / IN_WIDTH,
    parameter int LANE_BITS      = sn_clog2(RATIO),
    parameter int OUT_ADDR_WIDTH = IN_ADDR_WIDTH - LANE_BITS,
    parameter int IN_INC_WIDTH   = sn_clog2(IN_WIDTH / 8) + 1,
    parameter int OUT_INC_WIDTH  = sn_clog2(OUT_WIDTH / 8) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_ADDR_WIDTH-1:0]  in_addr,
    input  logic [IN_WIDTH-1:0]       in_wr_data,
    input  logic                      in_wr_en,
    input  logic [IN_INC_WIDTH-1:0]   in_byte_inc,
    input  logic                      in_done,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr,
    output logic [OUT_WIDTH-1:0]      out_wr_data,
    output logic                      out_wr_en,
    output logic [OUT_INC_WIDTH-1:0]  out_byte_inc,
    output logic                      out_done
);
    localparam int LW = sn_lane_w(RATIO);
    typedef struct packed {
        logic [OUT_ADDR_WIDTH-1:0] addr;
        logic [OUT_WIDTH-1:0]      data;
        logic [OUT_INC_WIDTH-1:0]  bytes;
    } word_t;
    sn_state_t state, state_n;
    word_t acc, acc_n, pend, pend_n, out_q, out_n, mrg;
    logic pend_valid, pend_valid_n, done_pend, done_pend_n, done_first, done_first_n;
    logic out_we_q, out_we_n, out_done_q, out_done_n;
    logic [LW-1:0] lane;
    logic [OUT_ADDR_WIDTH-1:0] waddr;
    logic [OUT_WIDTH-1:0] merged;
    logic [OUT_INC_WIDTH-1:0] m_bytes;
    logic disc, clear, complete, w1v, w2v, fire_old, taken;

    assign lane     = in_addr[LW-1:0] & LW'(RATIO - 1);
    assign waddr    = in_addr[IN_ADDR_WIDTH-1:LANE_BITS];
    assign disc     = in_wr_en && state == PARTIAL && waddr != acc.addr;
    assign clear    = state == EMPTY || disc;
    assign complete = lane == LW'(RATIO - 1);
    assign mrg      = {waddr, merged, m_bytes};
    // w1: the old word leaving early; w2: the word this beat finishes
    assign w1v      = state == PARTIAL && (disc || (in_done && !in_wr_en));
    assign w2v      = in_wr_en && (complete || in_done);
    // done_first marks a done that is older than the word sitting in pend
    assign fire_old = done_pend && (done_first || !pend_valid);
    assign taken    = fire_old || pend_valid;

    sn_lane_merge #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .LANE_W(LW),
        .IN_INC_WIDTH(IN_INC_WIDTH), .OUT_INC_WIDTH(OUT_INC_WIDTH)
    ) u_merge (
        .acc_data(acc.data), .beat(in_wr_data), .lane, .byte_inc(in_byte_inc),
        .clear, .merged, .bytes(m_bytes)
    );

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        out_n        = out_q;
        out_we_n     = 1'b0;
        out_done_n   = 1'b0;
        pend_n       = pend;
        pend_valid_n = 1'b1;
        if (in_wr_en) begin
            acc_n   = mrg;
            state_n = (complete || in_done) ? EMPTY : PARTIAL;
        end else if (in_done)
            state_n = EMPTY;
        // oldest item takes the output slot, the next one waits in pend
        if (fire_old) out_done_n = 1'b1;
        else if (pend_valid) {out_we_n, out_n} = {1'b1, pend};
        else if (w1v) {out_we_n, out_n} = {1'b1, acc};
        else if (w2v) {out_we_n, out_n} = {1'b1, mrg};
        else out_done_n = in_done;
        if (pend_valid && fire_old) pend_n = pend;
        else if (w1v && taken) pend_n = acc;
        else if (w2v && (taken || w1v)) pend_n = mrg;
        else pend_valid_n = 1'b0;
        done_first_n = done_pend && !fire_old;
        done_pend_n  = done_first_n || (in_done && (taken || w1v || w2v));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= EMPTY;
            acc        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            done_pend  <= 1'b0;
            done_first <= 1'b0;
            out_q      <= '0;
            out_we_q   <= 1'b0;
            out_done_q <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            done_pend  <= done_pend_n;
            done_first <= done_first_n;
            out_q      <= out_n;
            out_we_q   <= out_we_n;
            out_done_q <= out_done_n;
        end

    assign out_addr     = out_q.addr;
    assign out_wr_data  = out_q.data;
    assign out_byte_inc = out_q.bytes;
    assign out_wr_en    = out_we_q;
    assign out_done     = out_done_q;
endmodule
